// File: rtl/dotprod_job_sched_if.sv
// Host-job, kernel-control, memory-relocation and result channels of the
// dotprod job scheduler, bundled so the scheduler and its environment share one port list.
interface dotprod_job_sched_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_a_base;
    logic [AW-1:0] job_b_base;
    logic [31:0]   job_n;

    logic          k_ap_start;
    logic          k_ap_idle;
    logic          k_ap_done;
    logic [DW-1:0] k_ap_return;
    logic [31:0]   k_n;
    logic [AW-1:0] k_a_address0;
    logic          k_a_ce0;
    logic [AW-1:0] k_b_address0;
    logic          k_b_ce0;

    logic [AW-1:0] mem_a_address0;
    logic          mem_a_ce0;
    logic [AW-1:0] mem_b_address0;
    logic          mem_b_ce0;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_err;
    logic [15:0]   jobs_done;
    logic          sched_idle;

    modport slave (
        input  job_valid, job_a_base, job_b_base, job_n,
        input  k_ap_idle, k_ap_done, k_ap_return,
        input  k_a_address0, k_a_ce0, k_b_address0, k_b_ce0,
        input  res_ready,
        output job_ready, k_ap_start, k_n,
        output mem_a_address0, mem_a_ce0, mem_b_address0, mem_b_ce0,
        output res_valid, res_data, res_err, jobs_done, sched_idle
    );

    modport master (
        output job_valid, job_a_base, job_b_base, job_n,
        output k_ap_idle, k_ap_done, k_ap_return,
        output k_a_address0, k_a_ce0, k_b_address0, k_b_ce0,
        output res_ready,
        input  job_ready, k_ap_start, k_n,
        input  mem_a_address0, mem_a_ce0, mem_b_address0, mem_b_ce0,
        input  res_valid, res_data, res_err, jobs_done, sched_idle
    );
endinterface

// File: rtl/dotprod_job_sched.sv
// Queues dotprod jobs, launches the HLS kernel once per job with relocated a/b
// memory addresses, and returns each result (or a timeout error) over valid/ready.
module dotprod_job_sched #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    dotprod_job_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [AW-1:0] a_base;
        logic [AW-1:0] b_base;
        logic [31:0]   n;
    } job_t;

    state_t        r_state;
    state_t        w_state_nxt;
    job_t          r_fifo [DEPTH];
    job_t          r_job;
    job_t          w_head;
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_done_hit;
    logic          w_tmo_hit;
    logic          w_resp_hs;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_k_start;
    logic [DW-1:0] r_res_data;
    logic          r_res_err;
    logic [15:0]   r_jobs_done;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push  = bus.job_valid && !w_full;
    assign w_head  = r_fifo[r_rd_ptr[PW-1:0]];

    // NOTE: the storage array has no reset; the pointers alone say which entries are valid.
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PW-1:0]] <= {bus.job_a_base, bus.job_b_base, bus.job_n};
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop sees the pre-edge values of the others.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_hit  = 1'b0;
        w_tmo_hit   = 1'b0;
        w_resp_hs   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && bus.k_ap_idle) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_head.n == '0) ? S_RESP : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.k_ap_done) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_job       <= '0;
            r_k_start   <= 1'b0;
            r_tmo_cnt   <= '0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_jobs_done <= '0;
        end else begin
            if (r_state == S_RUN) r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_pop) begin
                r_job <= w_head;
                if (w_head.n == '0) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b0;
                end else begin
                    r_k_start <= 1'b1;
                    r_tmo_cnt <= '0;
                end
            end
            // Done is checked first so a completion on the last allowed cycle still counts.
            if (w_done_hit) begin
                r_res_data <= bus.k_ap_return;
                r_res_err  <= 1'b0;
                r_k_start  <= 1'b0;
            end else if (w_tmo_hit) begin
                r_res_data <= '0;
                r_res_err  <= 1'b1;
                r_k_start  <= 1'b0;
            end
            if (w_resp_hs) r_jobs_done <= r_jobs_done + 16'd1;
        end
    end

    assign bus.job_ready      = !w_full;
    assign bus.k_ap_start     = r_k_start;
    assign bus.k_n            = r_job.n;
    assign bus.mem_a_address0 = bus.k_a_address0 + r_job.a_base;
    assign bus.mem_b_address0 = bus.k_b_address0 + r_job.b_base;
    // RAM enables are gated so a kernel that is not ours to run cannot touch memory.
    assign bus.mem_a_ce0      = bus.k_a_ce0 && (r_state == S_RUN);
    assign bus.mem_b_ce0      = bus.k_b_ce0 && (r_state == S_RUN);
    assign bus.res_valid      = (r_state == S_RESP);
    assign bus.res_data       = r_res_data;
    assign bus.res_err        = r_res_err;
    assign bus.jobs_done      = r_jobs_done;
    assign bus.sched_idle     = (r_state == S_IDLE) && w_empty;
endmodule

// File: tb/tb_dotprod_job_sched.sv
// Directed bench for dotprod_job_sched: a latency-programmable kernel model plus
// a result scoreboard filled at job push and drained at each result handshake.
module tb_dotprod_job_sched;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    dotprod_job_sched_if #(.AW(AW), .DW(DW)) bus ();

    dotprod_job_sched #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            n_tests  = 0;
    int            n_fail   = 0;
    int            exp_done = 0;
    int            kern_lat = 0;
    logic [DW-1:0] kern_ret = '0;
    logic          stall    = 1'b0;
    int            kcnt     = 0;

    // Kernel model: done pulses on the kern_lat-th cycle of start; kern_lat==0 never finishes.
    always @(posedge ap_clk) begin
        #2;
        if (bus.k_ap_start && kern_lat != 0) begin
            kcnt++;
            bus.k_ap_done = (kcnt == kern_lat);
        end else begin
            kcnt = 0;
            bus.k_ap_done = 1'b0;
        end
        bus.k_ap_idle   = !stall && !bus.k_ap_start;
        bus.k_ap_return = kern_ret + bus.k_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [31:0] n);
        int i;
        bus.job_valid  = 1'b1;
        bus.job_a_base = a;
        bus.job_b_base = b;
        bus.job_n      = n;
        i = 0;
        while (!bus.job_ready && i < 100) begin
            tick();
            i++;
        end
        chk({tag, "_accept"}, bus.job_ready, 1);
        tick();
        bus.job_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic wait_result(input string tag);
        int   i;
        exp_t x;
        i = 0;
        while (!bus.res_valid && i < 200) begin
            tick();
            i++;
        end
        chk({tag, "_valid"}, bus.res_valid, 1);
        chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (bus.res_valid && sb.size() != 0) begin
            x = sb.pop_front();
            chk({tag, "_data"}, bus.res_data, x.data);
            chk({tag, "_err"}, bus.res_err, x.err);
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            exp_done++;
            chk({tag, "_jobs_done"}, bus.jobs_done, exp_done[15:0]);
            chk({tag, "_valid_drop"}, bus.res_valid, 0);
        end
    endtask

    task automatic count_start(input string tag, input int exp_cycles);
        int i;
        int n;
        i = 0;
        while (!bus.k_ap_start && i < 100) begin
            tick();
            i++;
        end
        n = 0;
        while (bus.k_ap_start && n < 200) begin
            n++;
            tick();
        end
        chk({tag, "_start_cycles"}, n, exp_cycles);
    endtask

    initial begin
        int   i;
        logic saw;
        logic ok;

        ap_rst            = 1'b1;
        bus.job_valid     = 1'b0;
        bus.job_a_base    = '0;
        bus.job_b_base    = '0;
        bus.job_n         = '0;
        bus.k_a_address0  = '0;
        bus.k_a_ce0       = 1'b1;
        bus.k_b_address0  = '0;
        bus.k_b_ce0       = 1'b1;
        bus.res_ready     = 1'b0;
        repeat (3) tick();
        ap_rst = 1'b0;
        tick();

        // Reset state; RAM enables must stay blocked outside RUN.
        chk("rst_start", bus.k_ap_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_err", bus.res_err, 0);
        chk("rst_jobs_done", bus.jobs_done, 0);
        chk("rst_idle", bus.sched_idle, 1);
        chk("rst_job_ready", bus.job_ready, 1);
        chk("rst_mem_a_ce", bus.mem_a_ce0, 0);
        chk("rst_k_n", bus.k_n, 0);

        // Basic job: 12-cycle kernel, address relocation, result 0x1E.
        kern_lat = 12;
        kern_ret = 32'h1A;
        push_job("t1", 32'h100, 32'h200, 32'd4);
        expect_res(32'h1E, 1'b0);
        chk("t1_no_start_at_accept", bus.k_ap_start, 0);
        chk("t1_busy", bus.sched_idle, 0);
        tick();
        chk("t1_start_next", bus.k_ap_start, 1);
        chk("t1_k_n", bus.k_n, 4);
        bus.k_a_address0 = 32'd3;
        bus.k_b_address0 = 32'd5;
        #1;
        chk("t1_mem_a_addr", bus.mem_a_address0, 32'h103);
        chk("t1_mem_b_addr", bus.mem_b_address0, 32'h205);
        chk("t1_mem_a_ce", bus.mem_a_ce0, 1);
        chk("t1_mem_b_ce", bus.mem_b_ce0, 1);
        count_start("t1", 12);
        wait_result("t1");

        // Zero-length job: kernel never started.
        push_job("n0", 32'h10, 32'h20, 32'd0);
        expect_res(32'h0, 1'b0);
        saw = 1'b0;
        i = 0;
        while (!bus.res_valid && i < 20) begin
            saw = saw | bus.k_ap_start;
            tick();
            i++;
        end
        saw = saw | bus.k_ap_start;
        chk("n0_no_start", saw, 0);
        wait_result("n0");

        // Kernel hangs: abort after TIMEOUT cycles, then a normal job.
        kern_lat = 0;
        push_job("to", 32'h0, 32'h0, 32'd7);
        expect_res(32'h0, 1'b1);
        count_start("to", TIMEOUT);
        wait_result("to");
        kern_lat = 3;
        kern_ret = 32'h0ABC;
        push_job("to_next", 32'h0, 32'h0, 32'd2);
        expect_res(32'h0ABE, 1'b0);
        count_start("to_next", 3);
        wait_result("to_next");

        // Result back-pressure: held stable, next job not launched.
        kern_lat = 2;
        kern_ret = 32'h5000;
        push_job("bp_a", 32'h0, 32'h0, 32'd6);
        expect_res(32'h5006, 1'b0);
        i = 0;
        while (!bus.res_valid && i < 50) begin
            tick();
            i++;
        end
        push_job("bp_b", 32'h0, 32'h0, 32'd7);
        expect_res(32'h5007, 1'b0);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ok = ok & (bus.res_valid === 1'b1) & (bus.res_data === 32'h5006) &
                 (bus.k_ap_start === 1'b0) & (bus.jobs_done === exp_done[15:0]);
            tick();
        end
        chk("bp_hold_stable", ok, 1);
        wait_result("bp_a");
        wait_result("bp_b");

        // Stalled kernel: FIFO fills at DEPTH, fifth job waits for the first pop.
        stall    = 1'b1;
        kern_lat = 2;
        kern_ret = 32'h7700;
        for (int k = 1; k <= DEPTH; k++) begin
            push_job("fill", 32'h0, 32'h0, 32'(k));
            expect_res(32'h7700 + 32'(k), 1'b0);
        end
        chk("fill_full", bus.job_ready, 0);
        bus.job_valid = 1'b1;
        bus.job_n     = 32'd5;
        repeat (3) tick();
        chk("fill_still_full", bus.job_ready, 0);
        chk("fill_no_launch", bus.k_ap_start, 0);
        stall = 1'b0;
        i = 0;
        while (!bus.job_ready && i < 50) begin
            tick();
            i++;
        end
        chk("fill_ready_again", bus.job_ready, 1);
        chk("fill_popped_first", bus.k_ap_start, 1);
        tick();
        bus.job_valid = 1'b0;
        expect_res(32'h7705, 1'b0);
        for (int k = 0; k < 5; k++) wait_result("order");

        // Reset mid-RUN with two jobs queued.
        kern_lat = 0;
        push_job("mr1", 32'h0, 32'h0, 32'd1);
        push_job("mr2", 32'h0, 32'h0, 32'd2);
        push_job("mr3", 32'h0, 32'h0, 32'd3);
        chk("mr_running", bus.k_ap_start, 1);
        chk("mr_not_idle", bus.sched_idle, 0);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        sb.delete();
        exp_done = 0;
        chk("mr_start", bus.k_ap_start, 0);
        chk("mr_idle", bus.sched_idle, 1);
        chk("mr_res_valid", bus.res_valid, 0);
        chk("mr_job_ready", bus.job_ready, 1);
        chk("mr_jobs_done", bus.jobs_done, 0);
        chk("mr_mem_a_ce", bus.mem_a_ce0, 0);

        // Address wrap: 0xFFFFFFF0 + 0x20 = 0x10.
        push_job("wrap", 32'hFFFF_FFF0, 32'h0, 32'd9);
        expect_res(32'h0, 1'b1);
        i = 0;
        while (!bus.k_ap_start && i < 20) begin
            tick();
            i++;
        end
        chk("wrap_start", bus.k_ap_start, 1);
        bus.k_a_address0 = 32'h20;
        #1;
        chk("wrap_mem_a_addr", bus.mem_a_address0, 32'h10);
        wait_result("wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
